// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, opcodes,
// ALU operations and datapath mux selects.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [4:0] OPR_ADD   = 5'h00;
  localparam logic [4:0] OPR_SUB   = 5'h08;
  localparam logic [4:0] OPR_SLT   = 5'h02;
  localparam logic [4:0] OPR_SLTU  = 5'h03;
  localparam logic [4:0] OPR_PASSB = 5'h1F;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;
  localparam logic [1:0] PC_INIT  = 2'b11;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PCIMM = 2'b10;
  localparam logic [1:0] WB_PC4   = 2'b11;

  function automatic logic is_known(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR) ||
           (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  function automatic logic [2:0] imm_for(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:           return IMM_J;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
// Level-based sideband: no handshake; the datapath holds opcode/funct3 stable
// from DECODE until the next FETCH and commits enables on the next rising clk.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] lorbtype;
  logic [3:0] alu_action;
  logic       zero;
  logic       PCsel1, PCsel0, enPC, ALUsrc;
  logic [2:0] immsrc;
  logic       memtoreg1, memtoreg0, read_mem, write_mem, enW;
  logic [4:0] opr;
  logic       illegal, retire;

  modport master (
    input  opcode, lorbtype, alu_action, zero,
    output PCsel1, PCsel0, enPC, ALUsrc, immsrc, memtoreg1, memtoreg0,
           read_mem, write_mem, enW, opr, illegal, retire
  );

  modport slave (
    output opcode, lorbtype, alu_action, zero,
    input  PCsel1, PCsel0, enPC, ALUsrc, immsrc, memtoreg1, memtoreg0,
           read_mem, write_mem, enW, opr, illegal, retire
  );
endinterface

// File: rtl/multicycle_ctrl_branch_resolve.sv
// Branch decision from funct3 and the ALU zero flag. For the compare forms
// the ALU produces SLT/SLTU, so zero=0 means "less than".
module branch_resolve
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       taken,
  output logic [4:0] opr
);
  always_comb begin
    opr   = OPR_SUB;
    taken = zero ^ funct3[0];
    if (funct3[2]) begin
      opr   = funct3[1] ? OPR_SLTU : OPR_SLT;
      taken = ~zero ^ funct3[0];
    end
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM. Optional MULTICYCLE_CTRL_PERF_EN adds
// cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  multicycle_ctrl_if.master bus,
  output state_t state_dbg
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t     state, next;
  logic [1:0] pcsel, wb_sel;
  logic       en_pc, alu_src, rd, wr, en_w, ret, set_illegal, illegal_q;
  logic [2:0] imm;
  logic [4:0] op, alu_opr, br_opr;
  logic       br_taken;

  branch_resolve u_branch (
    .funct3 (bus.lorbtype),
    .zero   (bus.zero),
    .taken  (br_taken),
    .opr    (br_opr)
  );

  assign alu_opr = {1'b0, bus.alu_action};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state <= next;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next        = state;
    pcsel       = PC_PLUS4;
    en_pc       = 1'b0;
    alu_src     = 1'b0;
    imm         = IMM_I;
    wb_sel      = WB_ALU;
    rd          = 1'b0;
    wr          = 1'b0;
    en_w        = 1'b0;
    op          = OPR_ADD;
    ret         = 1'b0;
    set_illegal = 1'b0;
    case (state)
      S_IDLE:  if (start) next = S_INIT;
      S_INIT: begin
        pcsel = PC_INIT;
        en_pc = 1'b1;
        next  = S_FETCH;
      end
      S_FETCH: next = S_DECODE;
      S_DECODE: begin
        imm = imm_for(bus.opcode);
        if (is_known(bus.opcode)) next = S_EXEC;
        else begin
          next        = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_EXEC: begin
        imm  = imm_for(bus.opcode);
        next = S_WB;
        case (bus.opcode)
          OP_R:   op = alu_opr;
          OP_IMM: begin alu_src = 1'b1; op = alu_opr; end
          OP_LOAD, OP_STORE: begin alu_src = 1'b1; next = S_MEM; end
          OP_BRANCH: begin
            op    = br_opr;
            pcsel = br_taken ? PC_IMM : PC_PLUS4;
            en_pc = 1'b1;
            ret   = 1'b1;
            next  = S_FETCH;
          end
          OP_JAL: begin
            en_w = 1'b1; wb_sel = WB_PC4; pcsel = PC_IMM;
            en_pc = 1'b1; ret = 1'b1; next = S_FETCH;
          end
          OP_JALR: begin
            alu_src = 1'b1; en_w = 1'b1; wb_sel = WB_PC4; pcsel = PC_ALU;
            en_pc = 1'b1; ret = 1'b1; next = S_FETCH;
          end
          OP_LUI:   begin alu_src = 1'b1; op = OPR_PASSB; end
          OP_AUIPC: ;
          default: begin next = S_HALT; set_illegal = 1'b1; end
        endcase
      end
      S_MEM: begin
        imm     = imm_for(bus.opcode);
        alu_src = 1'b1;
        if (bus.opcode == OP_LOAD) begin
          rd   = 1'b1;
          next = S_WB;
        end else begin
          wr    = 1'b1;
          en_pc = 1'b1;
          ret   = 1'b1;
          next  = S_FETCH;
        end
      end
      S_WB: begin
        // ALU controls are re-driven so the result stays valid at the commit edge.
        imm = imm_for(bus.opcode);
        case (bus.opcode)
          OP_R:     op = alu_opr;
          OP_IMM:   begin alu_src = 1'b1; op = alu_opr; end
          OP_LOAD:  begin alu_src = 1'b1; rd = 1'b1; wb_sel = WB_MEM; end
          OP_LUI:   begin alu_src = 1'b1; op = OPR_PASSB; end
          OP_AUIPC: wb_sel = WB_PCIMM;
          default:  ;
        endcase
        en_w  = 1'b1;
        en_pc = 1'b1;
        ret   = 1'b1;
        next  = S_FETCH;
      end
      S_HALT:  next = S_HALT;
      default: next = S_IDLE;
    endcase
  end

  assign bus.PCsel1    = pcsel[1];
  assign bus.PCsel0    = pcsel[0];
  assign bus.enPC      = en_pc;
  assign bus.ALUsrc    = alu_src;
  assign bus.immsrc    = imm;
  assign bus.memtoreg1 = wb_sel[1];
  assign bus.memtoreg0 = wb_sel[0];
  assign bus.read_mem  = rd;
  assign bus.write_mem = wr;
  assign bus.enW       = en_w;
  assign bus.opr       = op;
  assign bus.illegal   = illegal_q;
  assign bus.retire    = ret;
  assign state_dbg     = state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state != S_IDLE && state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (ret) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions, illegal halt,
// reset abort during load write-back, then randomized instruction stream.
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  logic   clk, reset, start;
  state_t state_dbg;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     rf_writes = 0;

  multicycle_ctrl_if dp ();

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (dp.master),
    .state_dbg (state_dbg)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file commit model: a write happens at a rising edge with enW high
  always @(posedge clk) if (dp.enW === 1'b1) rf_writes++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {PCsel[1:0], enPC, ALUsrc, immsrc[2:0], memtoreg[1:0], read_mem, write_mem, enW, opr[4:0], illegal, retire}
  function automatic logic [18:0] observed();
    return {dp.PCsel1, dp.PCsel0, dp.enPC, dp.ALUsrc, dp.immsrc, dp.memtoreg1, dp.memtoreg0,
            dp.read_mem, dp.write_mem, dp.enW, dp.opr, dp.illegal, dp.retire};
  endfunction

  // ---------------- reference model (instruction class x cycle number) ----------------
  function automatic int n_cycles(input logic [6:0] op);
    case (op)
      7'h63, 7'h6F, 7'h67: return 3;
      7'h03:               return 5;
      default:             return 4;
    endcase
  endfunction

  function automatic logic [2:0] model_imm(input logic [6:0] op);
    case (op)
      7'h23:        return 3'd1;
      7'h63:        return 3'd2;
      7'h37, 7'h17: return 3'd3;
      7'h6F:        return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic logic [18:0] model_out(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [3:0] alu, input logic z, input int k);
    logic [1:0] pcs = 2'b00;
    logic       enpc = 0, asrc = 0, rd = 0, wr = 0, enw = 0, ret = 0, tk;
    logic [2:0] imm = 3'd0;
    logic [1:0] m2r = 2'b00;
    logic [4:0] opr = 5'h00;
    int         n = n_cycles(op);
    if (k == 2) imm = model_imm(op);
    if (k == n) begin enpc = 1; ret = 1; end
    if (k >= 3) begin
      case (op)
        7'h33: begin opr = {1'b0, alu}; enw = (k == 4); end
        7'h13: begin asrc = 1; opr = {1'b0, alu}; enw = (k == 4); end
        7'h37: begin asrc = 1; opr = 5'h1F; enw = (k == 4); end
        7'h17: begin enw = (k == 4); if (k == 4) m2r = 2'b10; end
        7'h23: begin asrc = 1; wr = (k == 4); end
        7'h03: begin
          asrc = 1; rd = (k >= 4); enw = (k == 5);
          if (k == 5) m2r = 2'b01;
        end
        7'h63: begin
          case (f3)
            3'b000: begin tk = z;  opr = 5'h08; end
            3'b001: begin tk = !z; opr = 5'h08; end
            3'b100: begin tk = !z; opr = 5'h02; end
            3'b101: begin tk = z;  opr = 5'h02; end
            3'b110: begin tk = !z; opr = 5'h03; end
            default: begin tk = z; opr = 5'h03; end
          endcase
          pcs = tk ? 2'b01 : 2'b00;
        end
        7'h6F: begin enw = 1; m2r = 2'b11; pcs = 2'b01; end
        7'h67: begin asrc = 1; enw = 1; m2r = 2'b11; pcs = 2'b10; end
        default: ;
      endcase
    end
    return {pcs, enpc, asrc, imm, m2r, rd, wr, enw, opr, 1'b0, ret};
  endfunction

  // ---------------- driver tasks ----------------
  // Entered with the controller in FETCH, at 1 time unit after the edge.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [3:0] alu, input logic z);
    logic [18:0] obs;
    logic [18:0] exp;
    int n = n_cycles(op);
    dp.opcode = op; dp.lorbtype = f3; dp.alu_action = alu; dp.zero = z;
    for (int k = 1; k <= n; k++) begin
      #1;
      obs = observed();
      exp = model_out(op, f3, alu, z, k);
      if (k != 2) obs[14:12] = 3'd0;
      check_eq($sformatf("%s op=%h f3=%0d z=%0d c%0d", name, op, f3, z, k), 32'(obs), 32'(exp));
      if (k == 1) check_eq($sformatf("%s fetch_state", name), 32'(state_dbg), 32'(S_FETCH));
      step();
    end
  endtask

  // Entered with reset low; leaves the controller in FETCH after INIT.
  task automatic boot();
    step();
    check_eq("reset_outputs", 32'(observed()), 32'd0);
    check_eq("reset_state", 32'(state_dbg), 32'(S_IDLE));
    reset = 1'b1;
    step();
    start = 1'b1;
    #1;
    check_eq("idle_start_outputs", 32'(observed()), 32'd0);
    step();
    check_eq("init_outputs", 32'(observed()), 32'({2'b11, 1'b1, 16'b0}));
    check_eq("init_state", 32'(state_dbg), 32'(S_INIT));
    start = 1'b0;
    step();
  endtask

  logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  logic [2:0] br_f3 [6]     = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  initial begin
    int w0;
    logic [6:0] op;
    logic [2:0] f3;
    reset = 1'b0; start = 1'b0;
    dp.opcode = 7'h00; dp.lorbtype = 3'd0; dp.alu_action = 4'd0; dp.zero = 1'b0;
    boot();

    run_instr("add",  7'h33, 3'b000, 4'h0, 1'b0);
    run_instr("sub",  7'h33, 3'b000, 4'h8, 1'b1);
    run_instr("lw",   7'h03, 3'b010, 4'h0, 1'b0);
    run_instr("sw",   7'h23, 3'b010, 4'h0, 1'b0);
    run_instr("beq",  7'h63, 3'b000, 4'h0, 1'b1);
    run_instr("bne",  7'h63, 3'b001, 4'h0, 1'b1);
    run_instr("blt",  7'h63, 3'b100, 4'h0, 1'b0);
    run_instr("jal",  7'h6F, 3'b000, 4'h0, 1'b0);
    run_instr("jalr", 7'h67, 3'b000, 4'h0, 1'b0);
    run_instr("lui",  7'h37, 3'b000, 4'h0, 1'b0);
    run_instr("auipc",7'h17, 3'b000, 4'h0, 1'b0);

    // illegal opcode halts with only the sticky flag set; start is ignored
    dp.opcode = 7'h7F;
    #1;
    check_eq("ill_fetch", 32'(observed()), 32'd0);
    step();
    check_eq("ill_decode", 32'(observed()), 32'd0);
    step();
    check_eq("halt_outputs", 32'(observed()), 32'h2);
    check_eq("halt_state", 32'(state_dbg), 32'(S_HALT));
    start = 1'b1;
    step(); step();
    check_eq("halt_sticky", 32'(observed()), 32'h2);
    check_eq("halt_start_ignored", 32'(state_dbg), 32'(S_HALT));
    start = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("halt_reset_outputs", 32'(observed()), 32'd0);
    check_eq("halt_reset_state", 32'(state_dbg), 32'(S_IDLE));
    boot();

    // reset during load write-back aborts the register write
    dp.opcode = 7'h03; dp.lorbtype = 3'b010; dp.alu_action = 4'd0; dp.zero = 1'b0;
    repeat (4) step();
    #1;
    check_eq("lw_wb_enw", 32'(dp.enW), 32'd1);
    w0 = rf_writes;
    #2 reset = 1'b0;
    #1;
    check_eq("abort_enw", 32'(dp.enW), 32'd0);
    check_eq("abort_outputs", 32'(observed()), 32'd0);
    check_eq("abort_state", 32'(state_dbg), 32'(S_IDLE));
    step();
    check_eq("abort_no_rf_write", 32'(rf_writes), 32'(w0));
    boot();

    // randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      op = legal_ops[$urandom_range(0, 8)];
      f3 = (op == 7'h63) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      run_instr("rand", op, f3, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
